// File: rtl/axi_slave_mem_pkg.sv
// Shared types and constants for the AXI burst slave memory.
// Write/read FSM encodings, response codes and the burst-range helper.
package axi_slave_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned MAX_BURST   = 256;

    // True when the last beat of a burst would run past the top word of memory.
    function automatic logic burst_overflows(input logic [31:0] start_idx,
                                             input logic [7:0]  len,
                                             input int unsigned addr_width);
        return (start_idx + 32'(len)) > ((32'd1 << addr_width) - 32'd1);
    endfunction

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word-organised storage: one byte-enabled synchronous write port and one
// combinational read port. Contents are never cleared by reset.
module axi_slave_mem_ram #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave memory with independent write and read channels.
// Define AXI_SLAVE_MEM_ERR_EN to enable SLVERR on out-of-range bursts and wlast mismatches.
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int unsigned S_AXI_ID_WIDTH   = 1,
    parameter int unsigned S_AXI_DATA_WIDTH = 128,
    parameter int unsigned MEM_ADDR_WIDTH   = 10
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [31:0]                   s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [31:0]                   s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int unsigned BYTES = S_AXI_DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned CW    = $clog2(MAX_BURST);
`ifdef AXI_SLAVE_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;

    wstate_e                     wstate_q, wstate_d;
    logic [S_AXI_ID_WIDTH-1:0]   bid_q, bid_d;
    idx_t                        widx_q, widx_d;
    logic [CW-1:0]               wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                        wrng_err_q, wrng_err_d, wlast_err_q, wlast_err_d;

    rstate_e                     rstate_q, rstate_d;
    logic [S_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    idx_t                        ridx_q, ridx_d;
    logic [CW-1:0]               rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic                        rrng_err_q, rrng_err_d;
    logic [S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    idx_t                        aw_idx, ar_idx, ram_raddr;
    logic                        ram_we;
    logic [S_AXI_DATA_WIDTH-1:0] ram_rdata;
    logic                        unused_addr_bits;

    assign aw_idx = s_axi_awaddr[OFFS +: MEM_ADDR_WIDTH];
    assign ar_idx = s_axi_araddr[OFFS +: MEM_ADDR_WIDTH];

    axi_slave_mem_ram #(
        .DATA_WIDTH (S_AXI_DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_ram (
        .clk   (s_axi_aclk),
        .we    (ram_we),
        .waddr (widx_q),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wstate_q    <= W_IDLE;
            bid_q       <= '0;
            widx_q      <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wrng_err_q  <= 1'b0;
            wlast_err_q <= 1'b0;
            rstate_q    <= R_IDLE;
            rid_q       <= '0;
            ridx_q      <= '0;
            rlen_q      <= '0;
            rcnt_q      <= '0;
            rrng_err_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wstate_q    <= wstate_d;
            bid_q       <= bid_d;
            widx_q      <= widx_d;
            wlen_q      <= wlen_d;
            wcnt_q      <= wcnt_d;
            wrng_err_q  <= wrng_err_d;
            wlast_err_q <= wlast_err_d;
            rstate_q    <= rstate_d;
            rid_q       <= rid_d;
            ridx_q      <= ridx_d;
            rlen_q      <= rlen_d;
            rcnt_q      <= rcnt_d;
            rrng_err_q  <= rrng_err_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        wstate_d    = wstate_q;
        bid_d       = bid_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wrng_err_d  = wrng_err_q;
        wlast_err_d = wlast_err_q;
        case (wstate_q)
            W_IDLE: if (s_axi_awvalid) begin
                wstate_d    = W_DATA;
                bid_d       = s_axi_awid;
                widx_d      = aw_idx;
                wlen_d      = s_axi_awlen;
                wcnt_d      = '0;
                wrng_err_d  = ERR_EN && burst_overflows(32'(aw_idx), s_axi_awlen, MEM_ADDR_WIDTH);
                wlast_err_d = 1'b0;
            end
            W_DATA: if (s_axi_wvalid) begin
                widx_d      = widx_q + 1'b1;
                wcnt_d      = wcnt_q + 1'b1;
                wlast_err_d = wlast_err_q | (ERR_EN && (s_axi_wlast != (wcnt_q == wlen_q)));
                if (wcnt_q == wlen_q) begin
                    wstate_d = W_RESP;
                end
            end
            W_RESP: if (s_axi_bready) begin
                wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // rdata_q is preloaded one beat ahead so R outputs stay frozen while rready is low.
    always_comb begin
        rstate_d   = rstate_q;
        rid_d      = rid_q;
        ridx_d     = ridx_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        rrng_err_d = rrng_err_q;
        rdata_d    = rdata_q;
        case (rstate_q)
            R_IDLE: if (s_axi_arvalid) begin
                rstate_d   = R_DATA;
                rid_d      = s_axi_arid;
                ridx_d     = ar_idx;
                rlen_d     = s_axi_arlen;
                rcnt_d     = '0;
                rrng_err_d = ERR_EN && burst_overflows(32'(ar_idx), s_axi_arlen, MEM_ADDR_WIDTH);
                rdata_d    = ram_rdata;
            end
            R_DATA: if (s_axi_rready) begin
                if (rcnt_q == rlen_q) begin
                    rstate_d = R_IDLE;
                end else begin
                    ridx_d  = ridx_q + 1'b1;
                    rcnt_d  = rcnt_q + 1'b1;
                    rdata_d = ram_rdata;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready    = !s_axi_areset && (wstate_q == W_IDLE);
        s_axi_wready     = (wstate_q == W_DATA);
        s_axi_bvalid     = (wstate_q == W_RESP);
        s_axi_bid        = bid_q;
        s_axi_bresp      = (wrng_err_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
        s_axi_arready    = !s_axi_areset && (rstate_q == R_IDLE);
        s_axi_rvalid     = (rstate_q == R_DATA);
        s_axi_rid        = rid_q;
        s_axi_rdata      = rrng_err_q ? '0 : rdata_q;
        s_axi_rresp      = rrng_err_q ? RESP_SLVERR : RESP_OKAY;
        s_axi_rlast      = (rstate_q == R_DATA) && (rcnt_q == rlen_q);
        ram_we           = (wstate_q == W_DATA) && s_axi_wvalid && !wrng_err_q;
        ram_raddr        = (rstate_q == R_IDLE) ? ar_idx : ridx_q + 1'b1;
        unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: a word-array reference model predicts
// every B and R response; monitors pop and compare as the DUT presents them.
module tb_axi_slave_mem;

    localparam int unsigned IDW   = 4;
    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned BOUND = 3000;
`ifdef AXI_SLAVE_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [IDW-1:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [31:0]     s_axi_awaddr, s_axi_araddr;
    logic [7:0]      s_axi_awlen, s_axi_arlen;
    logic            s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [DW-1:0]   s_axi_wdata, s_axi_rdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic [1:0]      s_axi_bresp, s_axi_rresp;
    logic            s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic            s_axi_rlast, s_axi_rvalid, s_axi_rready;

    always #5 clk = ~clk;

    axi_slave_mem #(
        .S_AXI_ID_WIDTH   (IDW),
        .S_AXI_DATA_WIDTH (DW),
        .MEM_ADDR_WIDTH   (AW)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } rexp_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } bexp_t;

    rexp_t           rq[$];
    bexp_t           bq[$];
    logic [DW-1:0]   ref_mem   [DEPTH];
    logic [DW-1:0]   beat_data [256];
    logic [DW/8-1:0] beat_strb [256];
    int              checks = 0;
    int              passes = 0;
    int              rready_mode = 2;  // 0 random, 1 toggle, 2 high
    int              bready_mode = 2;  // 0 random, 1 held low, 2 high

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: got timeout/unexpected expected response", name);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rready_mode)
            0:       s_axi_rready = ($urandom_range(0, 3) != 0);
            1:       s_axi_rready = ~s_axi_rready;
            default: s_axi_rready = 1'b1;
        endcase
        case (bready_mode)
            0:       s_axi_bready = ($urandom_range(0, 2) != 0);
            1:       s_axi_bready = 1'b0;
            default: s_axi_bready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        rexp_t e;
        if (!rst && s_axi_rvalid && s_axi_rready) begin
            if (rq.size() == 0) fail("r_unexpected");
            else begin
                e = rq.pop_front();
                check("r_beat", 160'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
                      160'({e.id, e.data, e.resp, e.last}));
            end
        end
    end

    always @(negedge clk) begin
        bexp_t e;
        if (!rst && s_axi_bvalid && s_axi_bready) begin
            if (bq.size() == 0) fail("b_unexpected");
            else begin
                e = bq.pop_front();
                check("b_resp", 160'({s_axi_bid, s_axi_bresp}), 160'({e.id, e.resp}));
            end
        end
    end

    task automatic present_beat(input int unsigned n, input int unsigned len, input bit bad_wlast);
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = beat_data[n];
        s_axi_wstrb  = beat_strb[n];
        s_axi_wlast  = (n == len) ^ (bad_wlast && n == 0);
    endtask

    task automatic axi_write(input logic [IDW-1:0] id, input logic [31:0] addr,
                             input int unsigned len, input bit bad_wlast);
        int unsigned start, g, idx;
        bit          rng;
        bexp_t       be;
        start = (addr >> 4) % DEPTH;
        rng   = ERR_EN && (start + len > DEPTH - 1);
        for (int unsigned n = 0; n <= len; n++) begin
            idx = (start + n) % DEPTH;
            if (!rng)
                for (int unsigned b = 0; b < DW/8; b++)
                    if (beat_strb[n][b]) ref_mem[idx][8*b +: 8] = beat_data[n][8*b +: 8];
        end
        be.id   = id;
        be.resp = (ERR_EN && (rng || bad_wlast)) ? 2'b10 : 2'b00;
        bq.push_back(be);

        @(posedge clk); #1;
        s_axi_awvalid = 1'b1; s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        g = 0;
        @(negedge clk);
        while (!s_axi_awready && g < BOUND) begin @(negedge clk); g++; end
        if (!s_axi_awready) begin fail("aw_timeout"); s_axi_awvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        present_beat(0, len, bad_wlast);
        for (int unsigned n = 0; n <= len; n++) begin
            @(negedge clk);
            if (n == 0) check("wready_latency", 160'(s_axi_wready), 160'(1));
            g = 0;
            while (!s_axi_wready && g < BOUND) begin @(negedge clk); g++; end
            if (!s_axi_wready) begin fail("w_timeout"); s_axi_wvalid = 1'b0; return; end
            @(posedge clk); #1;
            if (n < len) present_beat(n + 1, len, bad_wlast);
            else s_axi_wvalid = 1'b0;
        end
        @(negedge clk);
        check("bvalid_latency", 160'(s_axi_bvalid), 160'(1));
    endtask

    task automatic axi_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int unsigned len);
        int unsigned start, g;
        bit          rng;
        rexp_t       e;
        start = (addr >> 4) % DEPTH;
        rng   = ERR_EN && (start + len > DEPTH - 1);
        for (int unsigned n = 0; n <= len; n++) begin
            e.id   = id;
            e.data = rng ? '0 : ref_mem[(start + n) % DEPTH];
            e.resp = rng ? 2'b10 : 2'b00;
            e.last = (n == len);
            rq.push_back(e);
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b1; s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        g = 0;
        @(negedge clk);
        while (!s_axi_arready && g < BOUND) begin @(negedge clk); g++; end
        if (!s_axi_arready) begin fail("ar_timeout"); s_axi_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_latency", 160'(s_axi_rvalid), 160'(1));
    endtask

    task automatic wait_r_done();
        int unsigned g = 0;
        while (rq.size() != 0 && g < BOUND) begin @(negedge clk); g++; end
        if (rq.size() != 0) begin fail("r_drain_timeout"); rq.delete(); end
    endtask

    task automatic wait_b_done();
        int unsigned g = 0;
        while (bq.size() != 0 && g < BOUND) begin @(negedge clk); g++; end
        if (bq.size() != 0) begin fail("b_drain_timeout"); bq.delete(); end
    endtask

    task automatic fill_beats(input int unsigned len, input bit full_strb);
        for (int unsigned n = 0; n <= len; n++) begin
            beat_data[n] = rand_word();
            beat_strb[n] = full_strb ? '1 : 16'($urandom);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned start, len;
        rst = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 160'(s_axi_awready), 160'(0));
        check("rst_wready",  160'(s_axi_wready),  160'(0));
        check("rst_bvalid",  160'(s_axi_bvalid),  160'(0));
        check("rst_arready", 160'(s_axi_arready), 160'(0));
        check("rst_rvalid",  160'(s_axi_rvalid),  160'(0));
        check("rst_rlast",   160'(s_axi_rlast),   160'(0));
        check("rst_resp_id", 160'({s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid}), 160'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 160'({s_axi_awready, s_axi_arready}), 160'(2'b11));

        // Single-beat write/read at 0x40
        beat_data[0] = {16{8'hA5}}; beat_strb[0] = '1;
        axi_write(4'h3, 32'h40, 0, 1'b0); wait_b_done();
        axi_read(4'h5, 32'h40, 0); wait_r_done();

        // 256-beat burst, rready toggling on readback
        for (int unsigned n = 0; n < 256; n++) begin
            beat_data[n] = DW'(n); beat_strb[n] = '1;
        end
        bready_mode = 0;
        axi_write(4'h1, 32'h0, 255, 1'b0); wait_b_done();
        rready_mode = 1;
        axi_read(4'h2, 32'h0, 255); wait_r_done();

        // Byte strobe on a single low byte
        beat_data[0] = '1; beat_strb[0] = '1;
        axi_write(4'h6, 32'h2580, 0, 1'b0); wait_b_done();
        beat_data[0] = '0; beat_strb[0] = 16'h0001;
        axi_write(4'h7, 32'h2580, 0, 1'b0); wait_b_done();
        rready_mode = 0;
        axi_read(4'h8, 32'h2580, 0); wait_r_done();

        // B held under back-pressure while a read proceeds
        bready_mode = 1; rready_mode = 2;
        fill_beats(0, 1'b1);
        axi_write(4'hA, 32'h2BC0, 0, 1'b0);
        fork
            begin axi_read(4'hB, 32'h0, 3); wait_r_done(); end
            repeat (6) begin
                @(negedge clk);
                check("b_stall_hold", 160'({s_axi_bvalid, s_axi_bid, s_axi_awready}),
                      160'({1'b1, 4'hA, 1'b0}));
            end
        join
        bready_mode = 0;
        wait_b_done();

        // Top-of-memory burst: wraps, or SLVERR when range checking is built in
        fill_beats(0, 1'b1); axi_write(4'h2, 32'h3FF0, 0, 1'b0); wait_b_done();
        fill_beats(0, 1'b1); axi_write(4'h3, 32'h0,    0, 1'b0); wait_b_done();
        fill_beats(1, 1'b1); axi_write(4'h4, 32'h3FF0, 1, 1'b0); wait_b_done();
        axi_read(4'h9, 32'h3FF0, 1); wait_r_done();

        // Misplaced wlast
        fill_beats(1, 1'b1); axi_write(4'hC, 32'h2600, 1, 1'b1); wait_b_done();
        axi_read(4'hD, 32'h2600, 1); wait_r_done();

        // Randomized traffic over a prefilled window of words 512..575
        rready_mode = 0;
        fill_beats(63, 1'b1);
        axi_write(4'h0, 32'h2000 | 32'($urandom_range(0, 15)), 63, 1'b0); wait_b_done();
        for (int unsigned it = 0; it < 30; it++) begin
            start = 512 + $urandom_range(0, 60);
            len   = $urandom_range(0, ((575 - start) < 15) ? (575 - start) : 15);
            if ($urandom_range(0, 1) == 0) begin
                fill_beats(len, 1'b0);
                axi_write(4'($urandom_range(0, 15)), 32'(start * 16 + $urandom_range(0, 15)), len,
                          ($urandom_range(0, 7) == 0));
                wait_b_done();
            end else begin
                axi_read(4'($urandom_range(0, 15)), 32'(start * 16 + $urandom_range(0, 15)), len);
                wait_r_done();
            end
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem
Interface
REQ-001 S_AXI_ID_WIDTH, default 1: width of all ID fields.
REQ-002 S_AXI_DATA_WIDTH, default 128: data bus width in bits (power of 2, >= 32); BYTES = S_AXI_DATA_WIDTH/8.
REQ-003 MEM_ADDR_WIDTH, default 10: log2 of memory depth in data words.
REQ-004 s_axi_aclk  input  1  sole clock, rising edge.
REQ-005 s_axi_areset  input  1  synchronous active-high reset.
REQ-006 s_axi_awid  input  S_AXI_ID_WIDTH  write burst ID.
REQ-007 s_axi_awaddr  input  32  write burst start byte address.
REQ-008 s_axi_awlen  input  8  write beats minus one.
REQ-009 s_axi_awvalid / s_axi_awready  input / output  1 each  AW handshake.
REQ-010 s_axi_wdata  input  S_AXI_DATA_WIDTH  write beat data.
REQ-011 s_axi_wstrb  input  BYTES  byte enables, bit i covers wdata[8i+7:8i].
REQ-012 s_axi_wlast  input  1  master last-beat marker.
REQ-013 s_axi_wvalid / s_axi_wready  input / output  1 each  W handshake.
REQ-014 s_axi_bid  output  S_AXI_ID_WIDTH  echo of latched awid.
REQ-015 s_axi_bresp  output  2  write response.
REQ-016 s_axi_bvalid / s_axi_bready  output / input  1 each  B handshake.
REQ-017 s_axi_arid  input  S_AXI_ID_WIDTH  read burst ID.
REQ-018 s_axi_araddr  input  32  read burst start byte address.
REQ-019 s_axi_arlen  input  8  read beats minus one.
REQ-020 s_axi_arvalid / s_axi_arready  input / output  1 each  AR handshake.
REQ-021 s_axi_rid  output  S_AXI_ID_WIDTH  echo of latched arid.
REQ-022 s_axi_rdata  output  S_AXI_DATA_WIDTH  read beat data.
REQ-023 s_axi_rresp  output  2  read response.
REQ-024 s_axi_rlast  output  1  high on final read beat.
REQ-025 s_axi_rvalid / s_axi_rready  output / input  1 each  R handshake.
Function
REQ-026 Bursts SHALL be INCR, full bus width; no burst/size/lock/cache/prot/qos ports; word index = addr[MEM_ADDR_WIDTH+log2(BYTES)-1 : log2(BYTES)], low bits ignored, index +1 per beat, modulo 2^MEM_ADDR_WIDTH.
REQ-027 Write FSM W_IDLE/W_DATA/W_RESP: awready=1 only in W_IDLE; AW handshake latches id, index, len, beat count=0 -> W_DATA.
REQ-028 W_DATA: wready=1; each W handshake writes strobed bytes to mem[index], index+1, count+1; handshake with count==len -> W_RESP; wlast never ends a burst.
REQ-029 W_RESP: bvalid=1, bid/bresp stable until bready; bvalid&&bready -> W_IDLE; awlen 0..255 gives 1..256 beats.
REQ-030 Read FSM R_IDLE/R_DATA: arready=1 only in R_IDLE; AR handshake latches id, index, len -> R_DATA; rvalid=1, rdata=mem[index], rlast=(count==len); rvalid and rdata/rlast/rresp/rid held until rready.
REQ-031 Latency: first wready and first rvalid one cycle after the address handshake; bvalid one cycle after last W beat; sustained 1 beat/cycle per channel.
REQ-032 Channels independent and concurrent; same-word read and write in one cycle returns pre-write data.
Reset
REQ-033 While s_axi_areset=1: FSMs to IDLE; awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid = 0; memory not cleared; a burst in flight is abandoned.
Configuration
REQ-034 AXI_SLAVE_MEM_ERR_EN defined: burst with start index + len > 2^MEM_ADDR_WIDTH-1 responds SLVERR (2'b10) on every R beat with rdata=0, or bresp SLVERR with all writes suppressed; wlast != (count==len) on any beat also gives bresp SLVERR.
REQ-035 AXI_SLAVE_MEM_ERR_EN undefined: bresp/rresp always OKAY (2'b00), index wraps per REQ-026, wlast ignored.
Structure
REQ-036 Package axi_slave_mem_pkg SHALL hold write/read FSM state enums, OKAY/SLVERR codes and MAX_BURST=256.
REQ-037 Storage SHALL be sub-module axi_slave_mem_ram: 1 write port with byte enables, 1 combinational read port.
Verification
REQ-038 Reset; write awaddr=0x40 awlen=0 wdata=0xA5..A5 strb all ones; read araddr=0x40 arlen=0 -> rdata=0xA5..A5, rlast=1, bresp=rresp=0.
REQ-039 Write 256 beats at 0x0, beat n data=n; read 256 beats, rready toggling every cycle -> data 0..255 in order, rlast only on beat 255.
REQ-040 Write all-0xFF word, then wstrb=0x0001 wdata=0 -> readback low byte 0x00, other bytes 0xFF.
REQ-041 bready low 5 cycles -> bvalid, bid held, awready stays 0; concurrent read burst completes meanwhile.
REQ-042 MEM_ADDR_WIDTH=10, 128-bit bus: araddr=0x3FF0 arlen=1 -> with macro 2 beats rresp=2'b10 rdata=0; without macro beat 0 from index 1023, beat 1 from index 0.
